pesanteur: RTL and testbench

Upstream control stage for the brick pile counter: turns a raw, bouncing "add brick" push-button into clean single-cycle `Plus` pulses and generates periodic gravity `Moins` pulses while the pile is non-empty. It drives the pile counter's `Plus`/`Moins` inputs and reads back its `Hauteur` output. Every pulse is followed by an idle cycle, so the pile counter's edge detector sees each request exactly once.

---
 rtl/pesanteur_if.sv | 12 +
 rtl/pesanteur.sv | 144 ++++++++++++++
 tb/tb_pesanteur.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pesanteur_if.sv
// Request/feedback bundle between the pesanteur control stage and the brick pile counter.
// The pile side (master) drives button, pause and height; pesanteur (slave) returns the pulses.
interface pesanteur_if;
  logic       btn_up;
  logic       pause;
  logic [2:0] Hauteur;
  logic       Plus;
  logic       Moins;

  modport master (output btn_up, output pause, output Hauteur, input Plus, input Moins);
  modport slave  (input btn_up, input pause, input Hauteur, output Plus, output Moins);
endinterface

// File: rtl/pesanteur.sv
// Brick pile control stage: debounced "add brick" presses become Plus pulses, a gravity timer
// produces Moins pulses while the pile is non-empty, every pulse being followed by an idle cycle.
module pesanteur #(
  parameter int GRAVITY_PERIOD  = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int MAX_HEIGHT      = 7
) (
  input  logic      clk,
  input  logic      reset,
  pesanteur_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GR_W = $clog2(GRAVITY_PERIOD);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GR_W-1:0] GR_LAST = GR_W'(GRAVITY_PERIOD - 1);
  localparam logic [2:0]      MAX_H   = 3'(MAX_HEIGHT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_P = 2'd1,
    PULSE_M = 2'd2,
    GAP     = 2'd3
  } state_t;

  logic            sync_p0;
  logic            sync_p1;
  logic            d;
  logic [DB_W-1:0] db_cnt;
  logic            db_fire;
  logic            d_rise;

  logic [GR_W-1:0] grav_cnt;
  logic            grav_wrap;
  logic            pile_empty;

  logic            press_pend;
  logic            grav_pend;
  logic            clr_press;
  logic            clr_grav;

  state_t          state;
  state_t          state_nxt;

  // Stage p0/p1: two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= bus.btn_up;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: the counter only runs while the synchronized level disagrees with d
  assign db_fire = (sync_p1 != d) && (db_cnt == DB_LAST);
  assign d_rise  = db_fire && sync_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      d      <= 1'b0;
      db_cnt <= '0;
    end else if (sync_p1 == d) begin
      db_cnt <= '0;
    end else if (db_fire) begin
      d      <= sync_p1;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Gravity timer: parked at zero on an empty pile, frozen (with its pending drop) while paused
  assign pile_empty = (bus.Hauteur == 3'd0);
  assign grav_wrap  = !pile_empty && !bus.pause && (grav_cnt == GR_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      grav_cnt <= '0;
    end else if (pile_empty) begin
      grav_cnt <= '0;
    end else if (!bus.pause) begin
      grav_cnt <= grav_wrap ? '0 : grav_cnt + 1'b1;
    end
  end

  // A new request arriving on the consuming edge wins, so it is not lost
  always_ff @(posedge clk) begin
    if (reset) begin
      press_pend <= 1'b0;
      grav_pend  <= 1'b0;
    end else begin
      if (d_rise) begin
        press_pend <= 1'b1;
      end else if (clr_press) begin
        press_pend <= 1'b0;
      end
      if (grav_wrap) begin
        grav_pend <= 1'b1;
      end else if (clr_grav) begin
        grav_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Height is only trusted in IDLE, where the pile counter has already absorbed the last pulse
  always_comb begin
    state_nxt = state;
    clr_press = 1'b0;
    clr_grav  = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_pend) begin
          clr_press = 1'b1;
          if (bus.Hauteur < MAX_H) begin
            state_nxt = PULSE_P;
          end
        end else if (grav_pend) begin
          clr_grav = 1'b1;
          if (!pile_empty) begin
            state_nxt = PULSE_M;
          end
        end
      end
      PULSE_P: state_nxt = GAP;
      PULSE_M: state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Plus  = (state == PULSE_P);
  assign bus.Moins = (state == PULSE_M);

endmodule

// File: tb/tb_pesanteur.sv
// Bench for pesanteur with a behavioural pile counter closed in the loop.
module tb_pesanteur;

  logic clk = 1'b0;
  logic reset;
  logic load_en;
  logic [2:0] load_val;
  logic [2:0] h;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  pesanteur_if ifc();

  pesanteur #(
    .GRAVITY_PERIOD (10),
    .DEBOUNCE_CYCLES(4),
    .MAX_HEIGHT     (7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pile counter model: reacts one edge after a pulse is presented
  always @(posedge clk) begin
    if (reset) h <= 3'd0;
    else if (load_en) h <= load_val;
    else if (ifc.Plus && h < 3'd7) h <= h + 3'd1;
    else if (ifc.Moins && h > 3'd0) h <= h - 3'd1;
  end
  assign ifc.Hauteur = h;

  typedef struct {
    bit btn;
    bit plus;
    bit moins;
    int hgt;
    bit deb;
  } vec_t;

  // One row per clock edge: clean press (rows 1-20), release (21-28), bounce (29-38)
  vec_t tbl [38] = '{
    '{1,0,0,0,0}, '{1,0,0,0,0}, '{1,0,0,0,0}, '{1,0,0,0,0}, '{1,0,0,0,0},
    '{1,0,0,0,1}, '{1,1,0,0,1}, '{1,0,0,1,1}, '{1,0,0,1,1}, '{1,0,0,1,1},
    '{1,0,0,1,1}, '{1,0,0,1,1}, '{1,0,0,1,1}, '{1,0,0,1,1}, '{1,0,0,1,1},
    '{1,0,0,1,1}, '{1,0,0,1,1}, '{1,0,0,1,1}, '{1,0,1,1,1}, '{1,0,0,0,1},
    '{0,0,0,0,1}, '{0,0,0,0,1}, '{0,0,0,0,1}, '{0,0,0,0,1}, '{0,0,0,0,1},
    '{0,0,0,0,0}, '{0,0,0,0,0}, '{0,0,0,0,0},
    '{1,0,0,0,0}, '{0,0,0,0,0}, '{1,0,0,0,0}, '{0,0,0,0,0},
    '{0,0,0,0,0}, '{0,0,0,0,0}, '{0,0,0,0,0}, '{0,0,0,0,0}, '{0,0,0,0,0}, '{0,0,0,0,0}
  };

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.btn_up = 1'b0;
    ifc.pause = 1'b0;
    load_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_h(input logic [2:0] v);
    load_en = 1'b1;
    load_val = v;
    tick();
    load_en = 1'b0;
  endtask

  int base;
  int n_plus;
  int n_moins;
  int plus_at;
  int moins_at;
  int offs [3];
  int wait_n;

  initial begin
    reset = 1'b1;
    load_en = 1'b0;
    load_val = 3'd0;
    ifc.btn_up = 1'b0;
    ifc.pause = 1'b0;
    @(negedge clk);
    do_reset();

    chk("reset_plus", ifc.Plus, 0);
    chk("reset_moins", ifc.Moins, 0);
    chk("reset_d", dut.d, 0);
    chk("reset_press_pend", dut.press_pend, 0);
    chk("reset_grav_pend", dut.grav_pend, 0);

    // Clean press, release and bounce rejection, edge by edge
    for (int i = 0; i < 38; i++) begin
      ifc.btn_up = tbl[i].btn;
      tick();
      chk($sformatf("tbl%0d_plus", i + 1), ifc.Plus, tbl[i].plus);
      chk($sformatf("tbl%0d_moins", i + 1), ifc.Moins, tbl[i].moins);
      chk($sformatf("tbl%0d_hauteur", i + 1), h, tbl[i].hgt);
      chk($sformatf("tbl%0d_d", i + 1), dut.d, tbl[i].deb);
    end

    // Gravity: height 3 drains with drops 10 cycles apart, then stays at 0
    do_reset();
    load_h(3'd3);
    base = cyc;
    n_moins = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (ifc.Moins) begin
        if (n_moins < 3) offs[n_moins] = cyc - base;
        n_moins++;
      end
    end
    chk("grav_count", n_moins, 3);
    chk("grav_first", offs[0], 11);
    chk("grav_second", offs[1], 21);
    chk("grav_third", offs[2], 31);
    chk("grav_final_h", h, 0);

    // Pause freezes the timer; resume continues from the held count
    do_reset();
    load_h(3'd3);
    repeat (5) tick();
    ifc.pause = 1'b1;
    n_moins = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (ifc.Moins) n_moins++;
    end
    chk("pause_no_moins", n_moins, 0);
    chk("pause_held_cnt", dut.grav_cnt, 5);
    chk("pause_h", h, 3);
    ifc.pause = 1'b0;
    wait_n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ifc.Moins && wait_n == 0) wait_n = k;
    end
    chk("resume_latency", wait_n, 6);

    // Collision: debounced press and gravity wrap land on the same edge
    do_reset();
    load_h(3'd2);
    base = cyc;
    repeat (4) tick();
    ifc.btn_up = 1'b1;
    n_plus = 0; n_moins = 0; plus_at = 0; moins_at = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (cyc - base == 10) begin
        chk("coll_press_pend", dut.press_pend, 1);
        chk("coll_grav_pend", dut.grav_pend, 1);
      end
      if (ifc.Plus) begin n_plus++; plus_at = cyc - base; end
      if (ifc.Moins) begin n_moins++; moins_at = cyc - base; end
      if (ifc.Plus && ifc.Moins) chk("coll_exclusive", 1, 0);
    end
    chk("coll_plus_count", n_plus, 1);
    chk("coll_plus_at", plus_at, 11);
    chk("coll_moins_count", n_moins, 1);
    chk("coll_moins_at", moins_at, 14);
    chk("coll_final_h", h, 2);
    ifc.btn_up = 1'b0;

    // Saturation: press at full height is discarded
    do_reset();
    ifc.pause = 1'b1;
    load_h(3'd7);
    ifc.btn_up = 1'b1;
    repeat (6) tick();
    chk("sat_press_pend_set", dut.press_pend, 1);
    tick();
    chk("sat_press_pend_clr", dut.press_pend, 0);
    n_plus = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ifc.Plus) n_plus++;
    end
    chk("sat_no_plus", n_plus, 0);
    chk("sat_h", h, 7);
    ifc.btn_up = 1'b0;
    ifc.pause = 1'b0;

    // Reset in the middle of a Plus pulse
    do_reset();
    ifc.btn_up = 1'b1;
    repeat (7) tick();
    chk("rst_plus_before", ifc.Plus, 1);
    ifc.btn_up = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_plus_after", ifc.Plus, 0);
    chk("rst_press_pend", dut.press_pend, 0);
    chk("rst_grav_pend", dut.grav_pend, 0);
    reset = 1'b0;
    n_plus = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (ifc.Plus) n_plus++;
    end
    chk("rst_no_pulse", n_plus, 0);
    ifc.btn_up = 1'b1;
    wait_n = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (ifc.Plus && wait_n == 0) wait_n = k;
    end
    chk("rst_fresh_press", wait_n, 7);
    ifc.btn_up = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
